// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csa_pkg
//  Description : Shared constants, operation encoding and stage-count helper
//                for the pipelined carry-skip adder/subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package csa_pkg;

    localparam int CSA_WIDTH          = 32;
    localparam int CSA_BLK_W          = 4;
    localparam int CSA_BLKS_PER_STAGE = 2;

    typedef enum logic {
        CSA_ADD = 1'b0,
        CSA_SUB = 1'b1
    } csa_op_e;

    // Number of pipeline stages for a given width, block size and blocks/stage.
    function automatic int csa_num_stages(input int width, input int blk_w, input int bps);
        return (width / blk_w) / bps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/carry_skip_block_p.sv
`default_nettype none
// ============================================================================
//  Module      : carry_skip_block_p
//  Description : One combinational carry-skip block. Ripples internally; the
//                carry-out bypasses the ripple chain when every bit
//                propagates.
//  Ports       : a, b  - BLK_W-bit operand slices
//                cin   - carry into the block
//                sum   - BLK_W-bit sum slice
//                cout  - carry out of the block
//  Revision    : 1.0 - initial release
// ============================================================================
module carry_skip_block_p #(
    parameter int BLK_W = 4
) (
    input  logic [BLK_W-1:0] a,
    input  logic [BLK_W-1:0] b,
    input  logic             cin,
    output logic [BLK_W-1:0] sum,
    output logic             cout
);

    logic [BLK_W-1:0] w_p;
    logic [BLK_W:0]   w_c;

    assign w_p = a ^ b;

    always_comb begin
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < BLK_W; i++) begin
            w_c[i+1] = (a[i] & b[i]) | (w_p[i] & w_c[i]);
        end
    end

    assign sum  = w_p ^ w_c[BLK_W-1:0];
    // When all bits propagate, the block's carry-out is simply its carry-in.
    assign cout = (&w_p) ? cin : w_c[BLK_W];

endmodule
`default_nettype wire

// File: rtl/carry_skip_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : carry_skip_adder_pipe
//  Description : Parametrised, pipelined carry-skip adder/subtractor with an
//                elastic valid/ready pipeline (full backpressure, no bubbles).
//                Each stage resolves BLKS_PER_STAGE skip blocks using the carry
//                registered by the previous stage.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                in_valid/in_ready        - input handshake
//                in_a, in_b, in_cin       - operands and carry-in
//                in_sub                   - 0: A+B+cin, 1: A-B (cin ignored)
//                out_valid/out_ready      - output handshake
//                out_sum, out_cout        - result and carry (1 = no borrow)
//                out_ovf                  - signed overflow (CSA_OVF_EN only)
//  Macro       : CSA_OVF_EN - adds out_ovf and the pipelined MSB sign bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module carry_skip_adder_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH          = CSA_WIDTH,
    parameter int BLK_W          = CSA_BLK_W,
    parameter int BLKS_PER_STAGE = CSA_BLKS_PER_STAGE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CSA_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int NUM_BLKS  = WIDTH / BLK_W;
    localparam int STAGES    = csa_num_stages(WIDTH, BLK_W, BLKS_PER_STAGE);
    localparam int c_STAGE_W = BLK_W * BLKS_PER_STAGE;

    if ((WIDTH % BLK_W) != 0) begin : g_chk_width
        $error("carry_skip_adder_pipe: WIDTH must be a multiple of BLK_W");
    end
    if ((NUM_BLKS % BLKS_PER_STAGE) != 0) begin : g_chk_bps
        $error("carry_skip_adder_pipe: NUM_BLKS must be a multiple of BLKS_PER_STAGE");
    end

    // Operand conditioning: subtraction is A + ~B + 1.
    csa_op_e          w_op;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_eff;

    assign w_op    = csa_op_e'(in_sub);
    assign w_b_eff = (w_op == CSA_SUB) ? ~in_b : in_b;
    assign w_c_eff = (w_op == CSA_SUB) ? 1'b1  : in_cin;

    // Per-stage register contents, exported from each generate scope.
    logic [STAGES:0]   w_rdy;
    logic [STAGES-1:0] w_v_q;
    logic [STAGES-1:0] w_c_q;
    logic [WIDTH-1:0]  w_a_q   [STAGES];
    logic [WIDTH-1:0]  w_b_q   [STAGES];
    logic [WIDTH-1:0]  w_sum_q [STAGES];
`ifdef CSA_OVF_EN
    logic [STAGES-1:0] w_amsb_q;
    logic [STAGES-1:0] w_bmsb_q;
`endif

    assign w_rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_v_in;
        logic             w_c_in;
        logic [WIDTH-1:0] w_a_in;
        logic [WIDTH-1:0] w_b_in;
        logic [WIDTH-1:0] w_sum_in;
`ifdef CSA_OVF_EN
        logic             w_amsb_in;
        logic             w_bmsb_in;
`endif

        // A stage may load when empty or when its successor is loading.
        assign w_rdy[k] = ~w_v_q[k] | w_rdy[k+1];

        if (k == 0) begin : g_src_in
            assign w_v_in   = in_valid;
            assign w_c_in   = w_c_eff;
            assign w_a_in   = in_a;
            assign w_b_in   = w_b_eff;
            assign w_sum_in = '0;
`ifdef CSA_OVF_EN
            assign w_amsb_in = in_a[WIDTH-1];
            assign w_bmsb_in = w_b_eff[WIDTH-1];
`endif
        end else begin : g_src_prev
            assign w_v_in   = w_v_q[k-1];
            assign w_c_in   = w_c_q[k-1];
            assign w_a_in   = w_a_q[k-1];
            assign w_b_in   = w_b_q[k-1];
            assign w_sum_in = w_sum_q[k-1];
`ifdef CSA_OVF_EN
            assign w_amsb_in = w_amsb_q[k-1];
            assign w_bmsb_in = w_bmsb_q[k-1];
`endif
        end

        logic [BLKS_PER_STAGE:0] w_cy;
        logic [c_STAGE_W-1:0]    w_slice;
        logic [WIDTH-1:0]        w_sum_nxt;

        assign w_cy[0] = w_c_in;

        for (genvar j = 0; j < BLKS_PER_STAGE; j++) begin : g_blk
            localparam int c_LSB = k * c_STAGE_W + j * BLK_W;
            carry_skip_block_p #(
                .BLK_W (BLK_W)
            ) u_blk (
                .a    (w_a_in[c_LSB +: BLK_W]),
                .b    (w_b_in[c_LSB +: BLK_W]),
                .cin  (w_cy[j]),
                .sum  (w_slice[j*BLK_W +: BLK_W]),
                .cout (w_cy[j+1])
            );
        end

        always_comb begin
            w_sum_nxt                            = w_sum_in;
            w_sum_nxt[k*c_STAGE_W +: c_STAGE_W] = w_slice;
        end

        logic             r_v;
        logic             r_c;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [WIDTH-1:0] r_sum;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_a   <= '0;
                r_b   <= '0;
                r_sum <= '0;
            end else if (w_rdy[k]) begin
                r_v   <= w_v_in;
                r_c   <= w_cy[BLKS_PER_STAGE];
                r_a   <= w_a_in;
                r_b   <= w_b_in;
                r_sum <= w_sum_nxt;
            end
        end

        assign w_v_q[k]   = r_v;
        assign w_c_q[k]   = r_c;
        assign w_a_q[k]   = r_a;
        assign w_b_q[k]   = r_b;
        assign w_sum_q[k] = r_sum;

`ifdef CSA_OVF_EN
        logic r_amsb;
        logic r_bmsb;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_amsb <= 1'b0;
                r_bmsb <= 1'b0;
            end else if (w_rdy[k]) begin
                r_amsb <= w_amsb_in;
                r_bmsb <= w_bmsb_in;
            end
        end

        assign w_amsb_q[k] = r_amsb;
        assign w_bmsb_q[k] = r_bmsb;
`endif
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = w_v_q[STAGES-1];
    assign out_sum   = w_sum_q[STAGES-1];
    assign out_cout  = w_c_q[STAGES-1];

`ifdef CSA_OVF_EN
    // Overflow: operands share a sign and the result sign differs from it.
    assign out_ovf = (w_amsb_q[STAGES-1] == w_bmsb_q[STAGES-1]) &&
                     (w_sum_q[STAGES-1][WIDTH-1] != w_amsb_q[STAGES-1]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_carry_skip_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_carry_skip_adder_pipe
//  Description : Self-checking bench for carry_skip_adder_pipe. Three
//                instances: default (32/4/2), 16/4/1 and 64/8/4. Results are
//                compared against plain A+B+cin / A-B arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_carry_skip_adder_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv   [3];
    logic        icin [3];
    logic        isub [3];
    logic        ordy [3];
    logic [63:0] ia   [3];
    logic [63:0] ib   [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        oc   [3];
    logic        oo   [3];
    logic [63:0] osum [3];

    logic [31:0] so0;
    logic [15:0] so1;
    logic [63:0] so2;

    assign osum[0] = {32'b0, so0};
    assign osum[1] = {48'b0, so1};
    assign osum[2] = so2;

    int total = 0;
    int bad   = 0;

    carry_skip_adder_pipe u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .in_a(ia[0][31:0]), .in_b(ib[0][31:0]), .in_cin(icin[0]), .in_sub(isub[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(so0), .out_cout(oc[0])
`ifdef CSA_OVF_EN
        , .out_ovf(oo[0])
`endif
    );

    carry_skip_adder_pipe #(.WIDTH(16), .BLK_W(4), .BLKS_PER_STAGE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .in_a(ia[1][15:0]), .in_b(ib[1][15:0]), .in_cin(icin[1]), .in_sub(isub[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(so1), .out_cout(oc[1])
`ifdef CSA_OVF_EN
        , .out_ovf(oo[1])
`endif
    );

    carry_skip_adder_pipe #(.WIDTH(64), .BLK_W(8), .BLKS_PER_STAGE(4)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(iv[2]), .in_ready(ir[2]),
        .in_a(ia[2]), .in_b(ib[2]), .in_cin(icin[2]), .in_sub(isub[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(so2), .out_cout(oc[2])
`ifdef CSA_OVF_EN
        , .out_ovf(oo[2])
`endif
    );

`ifndef CSA_OVF_EN
    assign oo[0] = 1'b0;
    assign oo[1] = 1'b0;
    assign oo[2] = 1'b0;
`endif

    function automatic int wid(input int d);
        return (d == 0) ? 32 : (d == 1) ? 16 : 64;
    endfunction

    function automatic int stg(input int d);
        return (d == 2) ? 2 : 4;
    endfunction

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? {64{1'b1}} : ((64'h1 << w) - 64'h1);
    endfunction

    // Reference: {ovf, (W+1)-bit result with carry at bit W}.
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [64:0] full;
        logic [64:0] r;
        logic        sa, sb, ovf;
        full = (65'h1 << (w + 1)) - 65'h1;
        if (sub) r = ({1'b0, a} - {1'b0, b} + (65'h1 << w)) & full;
        else     r = ({1'b0, a} + {1'b0, b} + {64'b0, cin}) & full;
        sa  = a[w-1];
        sb  = sub ? ~b[w-1] : b[w-1];
        ovf = (sa == sb) && (r[w-1] != sa);
        return {ovf, r};
    endfunction

    // Issue one operation with out_ready high and measure cycles to out_valid.
    task automatic run_one(input int d, input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input logic sub,
                           output logic [63:0] sum, output logic cout, output logic ovf,
                           output int lat);
        ordy[d] = 1'b1;
        ia[d] = a; ib[d] = b; icin[d] = cin; isub[d] = sub; iv[d] = 1'b1;
        #1;
        total++;
        if (ir[d] !== 1'b1) begin
            bad++; $display("FAIL issue_ready: dut%0d in_ready=%b want 1", d, ir[d]);
        end
        @(posedge clk); #1;
        iv[d] = 1'b0;
        lat = 1;
        while (ov[d] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        sum = osum[d]; cout = oc[d]; ovf = oo[d];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b1; ordy[d] = 1'b1; ia[d] = {$urandom, $urandom}; ib[d] = {$urandom, $urandom};
        end
        repeat (2) begin
            @(posedge clk); #1;
            total++;
            if (ov[0] !== 1'b0 || osum[0] !== 64'h0 || oc[0] !== 1'b0 || oo[0] !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs: valid=%b sum=%h cout=%b ovf=%b want 0/0/0/0",
                         ov[0], osum[0], oc[0], oo[0]);
            end
        end
        rst = 1'b0;
        for (int d = 0; d < 3; d++) iv[d] = 1'b0;
        #1;
        total++;
        if (ir[0] !== 1'b1 || ir[1] !== 1'b1 || ir[2] !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b%b%b want 111", ir[0], ir[1], ir[2]);
        end
        repeat (6) begin
            @(posedge clk); #1;
            total++;
            if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || ov[2] !== 1'b0) begin
                bad++; $display("FAIL reset_no_emit: out_valid=%b%b%b want 000", ov[0], ov[1], ov[2]);
            end
        end
    endtask

    task automatic test_skip_chain();
        logic [63:0] s; logic c, o; int lat;
        run_one(0, 64'hFFFF_FFFF, 64'h0, 1'b1, 1'b0, s, c, o, lat);
        total++;
        if (lat != 4) begin bad++; $display("FAIL skip_latency: got %0d want 4", lat); end
        total++;
        if (s !== 64'h0 || c !== 1'b1) begin
            bad++; $display("FAIL skip_result: sum=%h cout=%b want 0/1", s, c);
        end
        @(posedge clk); #1;
        total++;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL skip_single: out_valid=%b want 0", ov[0]); end
    endtask

    task automatic test_subtract();
        logic [63:0] s; logic c, o; int lat;
        run_one(0, 64'd5, 64'd7, 1'b0, 1'b1, s, c, o, lat);
        total++;
        if (s !== 64'hFFFF_FFFE || c !== 1'b0) begin
            bad++; $display("FAIL sub_borrow: sum=%h cout=%b want fffffffe/0", s, c);
        end
`ifdef CSA_OVF_EN
        total++;
        if (o !== 1'b0) begin bad++; $display("FAIL sub_ovf: got %b want 0", o); end
`endif
        // Carry-in must be ignored when subtracting.
        run_one(0, 64'd10, 64'd3, 1'b1, 1'b1, s, c, o, lat);
        total++;
        if (s !== 64'd7 || c !== 1'b1) begin
            bad++; $display("FAIL sub_cin_ignored: sum=%h cout=%b want 7/1", s, c);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] s; logic c, o; int lat;
        run_one(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0, s, c, o, lat);
        total++;
        if (s !== 64'hFFFF_FFFF || c !== 1'b1) begin
            bad++; $display("FAIL wrap: sum=%h cout=%b want ffffffff/1", s, c);
        end
        run_one(0, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, s, c, o, lat);
        total++;
        if (s !== 64'h8000_0000 || c !== 1'b0) begin
            bad++; $display("FAIL ovf_sum: sum=%h cout=%b want 80000000/0", s, c);
        end
`ifdef CSA_OVF_EN
        total++;
        if (o !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", o); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_config_latency();
        logic [63:0] s; logic c, o; int lat;
        run_one(1, 64'hFFFF, 64'h1, 1'b0, 1'b0, s, c, o, lat);
        total++;
        if (lat != 4 || s !== 64'h0 || c !== 1'b1) begin
            bad++; $display("FAIL cfg16_latency: lat=%0d sum=%h cout=%b want 4/0/1", lat, s, c);
        end
        run_one(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, s, c, o, lat);
        total++;
        if (lat != 2 || s !== 64'h0 || c !== 1'b1) begin
            bad++; $display("FAIL cfg64_latency: lat=%0d sum=%h cout=%b want 2/0/1", lat, s, c);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0, cyc = 0, occ;
        logic stalled = 1'b0, exp_ir;
        logic [63:0] prev;
        prev = '0;
        while (got < 8 && cyc < 100) begin
            iv[0] = (sent < 8); ia[0] = 64'(sent + 1); ib[0] = 64'(sent + 1);
            icin[0] = 1'b0; isub[0] = 1'b0;
            ordy[0] = !(cyc >= 4 && cyc < 9);
            #1;
            occ = sent - got;
            exp_ir = !(occ == 4 && !ordy[0]);
            total++;
            if (ir[0] !== exp_ir) begin
                bad++; $display("FAIL bp_in_ready: cyc=%0d got %b want %b", cyc, ir[0], exp_ir);
            end
            if (stalled) begin
                total++;
                if (ov[0] !== 1'b1 || osum[0] !== prev) begin
                    bad++; $display("FAIL bp_hold: valid=%b sum=%h want 1/%h", ov[0], osum[0], prev);
                end
            end
            if (ov[0] === 1'b1 && ordy[0]) begin
                total++;
                if (osum[0] !== 64'(2 * (got + 1))) begin
                    bad++; $display("FAIL bp_order: got %h want %h", osum[0], 64'(2 * (got + 1)));
                end
                got++;
            end
            if (iv[0] && ir[0] === 1'b1) sent++;
            stalled = (ov[0] === 1'b1) && !ordy[0];
            prev = osum[0];
            @(posedge clk); #1;
            cyc++;
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        total++;
        if (got != 8) begin bad++; $display("FAIL bp_count: got %0d results want 8", got); end
        repeat (6) begin
            @(posedge clk); #1;
            total++;
            if (ov[0] !== 1'b0) begin bad++; $display("FAIL bp_dup: out_valid=%b want 0", ov[0]); end
        end
    endtask

    task automatic test_reset_mid();
        ordy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1; ia[0] = 64'(i + 100); ib[0] = 64'h1; icin[0] = 1'b0; isub[0] = 1'b0;
            @(posedge clk); #1;
        end
        iv[0] = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ordy[0] = 1'b1;
        repeat (8) begin
            #1;
            total++;
            if (ov[0] !== 1'b0) begin bad++; $display("FAIL reset_mid: out_valid=%b want 0", ov[0]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random(input int d, input int n);
        logic [65:0] q[$];
        logic [65:0] e;
        logic [64:0] act;
        logic [63:0] m;
        logic        exp_ir, acc;
        int          w, cyc = 0, done_in = 0;
        w = wid(d); m = wmask(w);
        iv[d] = 1'b0;
        while ((done_in < n || q.size() > 0) && cyc < n * 8) begin
            if (!iv[d] && done_in < n && $urandom_range(3) != 0) begin
                iv[d] = 1'b1;
                case ($urandom_range(3))
                    0:       begin ia[d] = m; ib[d] = {$urandom, $urandom} & m; end
                    1:       begin ia[d] = {$urandom, $urandom} & m; ib[d] = ~ia[d] & m; end
                    default: begin ia[d] = {$urandom, $urandom} & m; ib[d] = {$urandom, $urandom} & m; end
                endcase
                icin[d] = 1'($urandom); isub[d] = 1'($urandom);
            end
            ordy[d] = ($urandom_range(3) != 0);
            #1;
            exp_ir = !(q.size() == stg(d) && !ordy[d]);
            total++;
            if (ir[d] !== exp_ir) begin
                bad++; $display("FAIL rnd%0d_in_ready: got %b want %b", d, ir[d], exp_ir);
            end
            if (ov[d] === 1'b1 && ordy[d]) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rnd%0d_spurious: got sum=%h want no output", d, osum[d]);
                end else begin
                    e = q.pop_front();
                    act = {1'b0, osum[d] & m} | ({64'b0, oc[d]} << w);
                    if (act !== e[64:0]) begin
                        bad++; $display("FAIL rnd%0d_result: got %h want %h", d, act, e[64:0]);
                    end
`ifdef CSA_OVF_EN
                    else if (oo[d] !== e[65]) begin
                        bad++; $display("FAIL rnd%0d_ovf: got %b want %b", d, oo[d], e[65]);
                    end
`endif
                end
            end
            acc = iv[d] && (ir[d] === 1'b1);
            if (acc) begin
                q.push_back(model(w, ia[d], ib[d], icin[d], isub[d]));
                done_in++;
            end
            @(posedge clk); #1;
            if (acc) iv[d] = 1'b0;
            cyc++;
        end
        iv[d] = 1'b0; ordy[d] = 1'b1;
        total++;
        if (done_in != n || q.size() != 0) begin
            bad++; $display("FAIL rnd%0d_timeout: issued=%0d pending=%0d want %0d/0", d, done_in, q.size(), n);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; icin[d] = 1'b0; isub[d] = 1'b0; ordy[d] = 1'b1; ia[d] = '0; ib[d] = '0;
        end
        test_reset();
        test_skip_chain();
        test_subtract();
        test_overflow();
        test_config_latency();
        test_backpressure();
        test_reset_mid();
        test_random(1, 10000);
        test_random(2, 10000);
        test_random(0, 2000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
